// File: rtl/fft16_pkg.sv
// Shared constants and FSM encoding for the 16-point FFT
// butterfly scheduler.
package fft16_pkg;

   localparam int N       = 16;
   localparam int LOG2N   = 4;
   localparam int ADDR_W  = 4;
   localparam int TW_W    = 3;
   localparam int TIMEOUT = 63;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_FINISH
   } state_t;

endpackage

// File: rtl/fft16_addr_gen.sv
// In-place radix-2 DIT address and twiddle generation
// for stage s, butterfly k.
module fft16_addr_gen
   import fft16_pkg::*;
(
   input  logic [1:0]        stage,
   input  logic [2:0]        bf,
   output logic [ADDR_W-1:0] addr0,
   output logic [ADDR_W-1:0] addr1,
   output logic [TW_W-1:0]   tw
);

   logic [ADDR_W-1:0] kx;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] hi;
   logic [TW_W-1:0]   lo;

   always_comb begin
      kx    = {1'b0, bf};
      span  = ADDR_W'(1) << stage;
      lo    = bf & TW_W'(span - 1'b1);
      // group base: drop the low s bits of k, leave a gap bit for the span
      hi    = (kx >> stage) << ({1'b0, stage} + 3'd1);
      addr0 = hi | {1'b0, lo};
      addr1 = addr0 + span;
      tw    = lo << (2'd3 - stage);
   end

endmodule

// File: rtl/fft16_bf_scheduler.sv
// Steps one shared radix-2 butterfly through the 4x8
// operations of an in-place 16-point DIT FFT.
module fft16_bf_scheduler #(
   parameter int ADDR_W  = fft16_pkg::ADDR_W,
   parameter int TW_W    = fft16_pkg::TW_W,
   parameter int TIMEOUT = fft16_pkg::TIMEOUT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [1:0]        o_stage,
   output logic [ADDR_W-1:0] o_rd_addr0,
   output logic [ADDR_W-1:0] o_rd_addr1,
   output logic [TW_W-1:0]   o_tw_idx,
   output logic              o_bf_start,
   input  logic              i_bf_done,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr0,
   output logic [ADDR_W-1:0] o_wr_addr1
);

   import fft16_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        s;
   logic [1:0]        s_nxt;
   logic [2:0]        k;
   logic [2:0]        k_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              done_q;
   logic              bf_edge;
   logic              tmo;
   logic              err;
   logic [ADDR_W-1:0] a0_d;
   logic [ADDR_W-1:0] a1_d;
   logic [TW_W-1:0]   tw_d;
   logic [ADDR_W-1:0] a0_q;
   logic [ADDR_W-1:0] a1_q;
   logic [TW_W-1:0]   tw_q;

   assign bf_edge = i_bf_done & ~done_q;
   assign tmo     = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (i_start) state_nxt = S_ISSUE;
         S_ISSUE:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (bf_edge)  state_nxt = S_WRITE;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_WRITE: begin
            if (k == 3'd7 && s == 2'd3) state_nxt = S_FINISH;
            else                        state_nxt = S_ISSUE;
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_bf_start = 1'b0;
      o_wr_en    = 1'b0;
      o_done     = 1'b0;
      o_busy     = 1'b1;
      unique case (state)
         S_IDLE:   o_busy     = 1'b0;
         S_ISSUE:  o_bf_start = 1'b1;
         S_WAIT:   o_busy     = 1'b1;
         S_WRITE:  o_wr_en    = 1'b1;
         S_FINISH: o_done     = 1'b1;
         default:  o_busy     = 1'b0;
      endcase
   end

   always_comb begin
      s_nxt = s;
      k_nxt = k;
      if (state == S_IDLE && i_start) begin
         s_nxt = 2'd0;
         k_nxt = 3'd0;
      end else if (state == S_WRITE) begin
         if (k == 3'd7) begin
            k_nxt = 3'd0;
            if (s != 2'd3) s_nxt = s + 2'd1;
         end else begin
            k_nxt = k + 3'd1;
         end
      end
   end

   // addresses are computed for the op about to issue, then held
   fft16_addr_gen u_addr_gen (
      .stage (s_nxt),
      .bf    (k_nxt),
      .addr0 (a0_d),
      .addr1 (a1_d),
      .tw    (tw_d)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s      <= '0;
         k      <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         err    <= 1'b0;
         a0_q   <= '0;
         a1_q   <= '0;
         tw_q   <= '0;
      end else begin
         done_q <= i_bf_done;
         s      <= s_nxt;
         k      <= k_nxt;
         if (state_nxt == S_ISSUE) begin
            a0_q <= a0_d;
            a1_q <= a1_d;
            tw_q <= tw_d;
         end
         if (state == S_ISSUE)
            cnt <= '0;
         else if (state == S_WAIT && !bf_edge && !tmo)
            cnt <= cnt + 1'b1;
         if (state == S_IDLE && i_start)
            err <= 1'b0;
         else if (state == S_WAIT && !bf_edge && tmo)
            err <= 1'b1;
      end
   end

   assign o_err      = err;
   assign o_stage    = s;
   assign o_rd_addr0 = a0_q;
   assign o_rd_addr1 = a1_q;
   assign o_tw_idx   = tw_q;
   assign o_wr_addr0 = a0_q;
   assign o_wr_addr1 = a1_q;

endmodule

// File: tb/tb_fft16_bf_scheduler.sv
// Directed bench for the FFT butterfly scheduler.
// Cycle 0 is the edge that samples i_start.
module tb_fft16_bf_scheduler;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_start;
   logic       i_bf_done;
   logic       o_busy;
   logic       o_done;
   logic       o_err;
   logic [1:0] o_stage;
   logic [3:0] o_rd_addr0;
   logic [3:0] o_rd_addr1;
   logic [2:0] o_tw_idx;
   logic       o_bf_start;
   logic       o_wr_en;
   logic [3:0] o_wr_addr0;
   logic [3:0] o_wr_addr1;

   int n_checks = 0;
   int n_fail   = 0;

   int exp_a0 [32] = '{0, 2, 4, 6, 8, 10, 12, 14,
                       0, 1, 4, 5, 8, 9, 12, 13,
                       0, 1, 2, 3, 8, 9, 10, 11,
                       0, 1, 2, 3, 4, 5, 6, 7};
   int exp_tw [32] = '{0, 0, 0, 0, 0, 0, 0, 0,
                       0, 4, 0, 4, 0, 4, 0, 4,
                       0, 2, 4, 6, 0, 2, 4, 6,
                       0, 1, 2, 3, 4, 5, 6, 7};
   int exp_h [4]   = '{1, 2, 4, 8};

   always #5 clk = ~clk;

   fft16_bf_scheduler dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err      (o_err),
      .o_stage    (o_stage),
      .o_rd_addr0 (o_rd_addr0),
      .o_rd_addr1 (o_rd_addr1),
      .o_tw_idx   (o_tw_idx),
      .o_bf_start (o_bf_start),
      .i_bf_done  (i_bf_done),
      .o_wr_en    (o_wr_en),
      .o_wr_addr0 (o_wr_addr0),
      .o_wr_addr1 (o_wr_addr1)
   );

   function automatic logic [25:0] outs();
      return {o_busy, o_done, o_err, o_stage, o_rd_addr0,
              o_rd_addr1, o_tw_idx, o_bf_start, o_wr_en,
              o_wr_addr0, o_wr_addr1};
   endfunction

   task automatic test_reset();
      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_bf_done = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (outs() !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h want 0", outs());
      end
      i_rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (outs() !== 26'd0) begin
         n_fail++;
         $display("FAIL idle_outs: got %h want 0", outs());
      end
   endtask

   // Butterfly model raises done in the d-th WAIT cycle.
   // pa/pb: cycles to pulse i_start; abort_c: return early.
   task automatic run_fft(input int d, input int exp_done_c,
                          input int pa, input int pb,
                          input int abort_c);
      int op, issue_c, pend, nwr;
      bit active, finished;
      logic [3:0] e0, e1;
      logic [2:0] et;
      op = -1; issue_c = 0; pend = -1; nwr = 0;
      active = 1'b0; finished = 1'b0;
      e0 = '0; e1 = '0; et = '0;
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         if (c == abort_c) return;
         i_start = (c == pa || c == pb);
         if (c == 1) begin
            n_checks++;
            if (o_bf_start !== 1'b1 || o_err !== 1'b0) begin
               n_fail++;
               $display("FAIL first_issue: got start=%b err=%b want 1 0",
                        o_bf_start, o_err);
            end
         end
         if (o_bf_start === 1'b1) begin
            op++; issue_c = c; pend = c + d; active = 1'b1;
            if (op > 31) begin
               n_checks++; n_fail++;
               $display("FAIL op_count: got %0d want <=31", op);
               active = 1'b0;
            end else begin
               e0 = 4'(exp_a0[op]);
               e1 = 4'(exp_a0[op] + exp_h[op / 8]);
               et = 3'(exp_tw[op]);
               n_checks++;
               if (o_stage !== 2'(op / 8)) begin
                  n_fail++;
                  $display("FAIL stage op%0d: got %0d want %0d",
                           op, o_stage, op / 8);
               end
            end
         end
         if (active) begin
            n_checks++;
            if (o_rd_addr0 !== e0 || o_rd_addr1 !== e1 ||
                o_tw_idx !== et) begin
               n_fail++;
               $display("FAIL rd op%0d c%0d: got %0d,%0d tw%0d want %0d,%0d tw%0d",
                        op, c, o_rd_addr0, o_rd_addr1, o_tw_idx, e0, e1, et);
            end
         end
         if (o_wr_en === 1'b1) begin
            nwr++;
            n_checks++;
            if (!active || c != issue_c + d + 1 ||
                o_wr_addr0 !== e0 || o_wr_addr1 !== e1) begin
               n_fail++;
               $display("FAIL write op%0d: got c%0d %0d,%0d want c%0d %0d,%0d",
                        op, c, o_wr_addr0, o_wr_addr1,
                        issue_c + d + 1, e0, e1);
            end
            active = 1'b0;
         end
         i_bf_done = (c == pend);
         n_checks++;
         if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy c%0d: got %b want 1", c, o_busy);
         end
         if (o_done === 1'b1) begin
            n_checks++;
            if (c != exp_done_c || nwr != 32 || op != 31) begin
               n_fail++;
               $display("FAIL done: got c%0d wr%0d op%0d want c%0d wr32 op31",
                        c, nwr, op, exp_done_c);
            end
            finished = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!finished) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: got no done want c%0d", exp_done_c);
      end
      @(negedge clk);
      i_start   = 1'b0;
      i_bf_done = 1'b0;
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (o_busy !== 1'b0 || o_done !== 1'b0 ||
             o_bf_start !== 1'b0) begin
            n_fail++;
            $display("FAIL post_idle %0d: got busy=%b done=%b start=%b want 0",
                     j, o_busy, o_done, o_bf_start);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_basic();
      run_fft(1, 97, 0, 0, 0);
   endtask

   task automatic test_slow();
      run_fft(12, 449, 0, 0, 0);
   endtask

   task automatic test_timeout();
      int last;
      bit seen_done;
      last = 0;
      seen_done = 1'b0;
      i_bf_done = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (o_done === 1'b1) seen_done = 1'b1;
         if (o_busy !== 1'b1) begin
            last = c;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (last != 65 || seen_done) begin
         n_fail++;
         $display("FAIL tmo_len: got idle at c%0d done=%b want c65 0",
                  last, seen_done);
      end
      n_checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_flags: got err=%b busy=%b done=%b want 1 0 0",
                  o_err, o_busy, o_done);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want 1", o_err);
      end
      run_fft(1, 97, 0, 0, 0);
   endtask

   task automatic test_ignore_start();
      run_fft(1, 97, 2, 97, 0);
   endtask

   task automatic test_reset_mid();
      run_fft(1, 97, 0, 0, 50);
      n_checks++;
      if (o_stage !== 2'd2 || o_busy !== 1'b1 || o_bf_start !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_rst: got s%0d busy=%b start=%b want s2 1 0",
                  o_stage, o_busy, o_bf_start);
      end
      i_bf_done = 1'b0;
      i_start   = 1'b0;
      i_rst     = 1'b1;
      #1;
      n_checks++;
      if (outs() !== 26'd0) begin
         n_fail++;
         $display("FAIL mid_rst_outs: got %h want 0", outs());
      end
      @(negedge clk);
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst: got done=%b busy=%b want 0 0",
                  o_done, o_busy);
      end
      run_fft(1, 97, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow();
      test_timeout();
      test_ignore_start();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
